// File: rtl/mesh_edge_pkg.sv
// mesh_edge_pkg: shared types, LFSR constants and port-count helper for the mesh edge-port agent
package mesh_edge_pkg;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'd0,
        DELAY     = 2'd1,
        LFSR      = 2'd2,
        HOLD      = 2'd3
    } ack_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_GAP  = 2'd3
    } sink_state_e;

    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the XOR of bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int nports(input int rows, input int cols);
        return rows * 2 + cols * 2;
    endfunction

endpackage

// File: rtl/mesh_edge_fifo.sv
// mesh_edge_fifo: synchronous FIFO with registered full/empty flags
//   clk, reset     : clock, synchronous active-high reset
//   push, wdata    : write request and word (ignored when full)
//   pop            : retire head word (ignored when empty)
//   rdata          : head word
//   full, empty    : registered status flags
module mesh_edge_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
    assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Flags are registered from the next-state pointers; full is same index with opposite wrap bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            empty  <= wr_nxt == rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mesh_edge_ports.sv
// mesh_edge_ports: TX/RX endpoint terminating every boundary port of the mesh router
//   clk, reset                       : clock, synchronous active-high reset
//   cfg_mode, cfg_delay              : eject ack mode (IMMEDIATE/DELAY/LFSR/HOLD) and DELAY wait
//   tx_valid, tx_data, tx_ready      : upstream words into the per-port TX FIFOs
//   pndng_i_in, data_out_i_in, pop   : TX FIFO head presented to the router, retired on pop
//   pndng, data_out, popin           : router output consumed by the per-port sink FSM
//   rx_valid, rx_data, rx_ready      : captured words from the per-port RX FIFOs
//   err_sticky                       : protocol error flags, live only when MESH_EDGE_CHECK_EN is defined
module mesh_edge_ports
    import mesh_edge_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int PCKG_SZ    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DLY_W      = 8,
    localparam int NPORTS    = nports(ROWS, COLUMS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                cfg_mode,
    input  logic [DLY_W-1:0]          cfg_delay,
    input  logic [NPORTS-1:0]         tx_valid,
    input  logic [NPORTS*PCKG_SZ-1:0] tx_data,
    output logic [NPORTS-1:0]         tx_ready,
    output logic [NPORTS-1:0]         pndng_i_in,
    output logic [NPORTS*PCKG_SZ-1:0] data_out_i_in,
    input  logic [NPORTS-1:0]         pop,
    input  logic [NPORTS-1:0]         pndng,
    input  logic [NPORTS*PCKG_SZ-1:0] data_out,
    output logic [NPORTS-1:0]         popin,
    output logic [NPORTS-1:0]         rx_valid,
    output logic [NPORTS*PCKG_SZ-1:0] rx_data,
    input  logic [NPORTS-1:0]         rx_ready,
    output logic [NPORTS-1:0]         err_sticky
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        lfsr <= reset ? LFSR_SEED : {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic tx_full, tx_empty, rx_full, rx_empty, ack;
        logic wait_delay, wait_delay_nxt;
        logic [DLY_W-1:0] cnt, cnt_nxt;
        sink_state_e state, state_nxt;

        mesh_edge_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx (
            .clk   (clk),
            .reset (reset),
            .push  (tx_valid[p]),
            .wdata (tx_data[p*PCKG_SZ +: PCKG_SZ]),
            .pop   (pop[p]),
            .rdata (data_out_i_in[p*PCKG_SZ +: PCKG_SZ]),
            .full  (tx_full),
            .empty (tx_empty)
        );

        mesh_edge_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_rx (
            .clk   (clk),
            .reset (reset),
            .push  (ack),
            .wdata (data_out[p*PCKG_SZ +: PCKG_SZ]),
            .pop   (rx_ready[p]),
            .rdata (rx_data[p*PCKG_SZ +: PCKG_SZ]),
            .full  (rx_full),
            .empty (rx_empty)
        );

        // Flags are not yet valid on the first reset edge, so force tx_ready low throughout reset.
        assign tx_ready[p]   = !tx_full && !reset;
        assign pndng_i_in[p] = !tx_empty;
        assign rx_valid[p]   = !rx_empty;
        assign popin[p]      = ack;

        always_ff @(posedge clk) begin
            if (reset) begin
                state      <= S_IDLE;
                cnt        <= '0;
                wait_delay <= 1'b0;
            end else begin
                state      <= state_nxt;
                cnt        <= cnt_nxt;
                wait_delay <= wait_delay_nxt;
            end
        end

        // wait_delay remembers which mode started the WAIT, so a mode change mid-wait
        // only affects the next packet.
        always_comb begin
            state_nxt      = state;
            cnt_nxt        = cnt;
            wait_delay_nxt = wait_delay;
            case (state)
                S_IDLE: begin
                    if (pndng[p] && !rx_full) begin
                        case (ack_mode_e'(cfg_mode))
                            IMMEDIATE: state_nxt = S_ACK;
                            DELAY: begin
                                cnt_nxt        = cfg_delay;
                                wait_delay_nxt = 1'b1;
                                state_nxt      = (cfg_delay == '0) ? S_ACK : S_WAIT;
                            end
                            LFSR: begin
                                wait_delay_nxt = 1'b0;
                                state_nxt      = S_WAIT;
                            end
                            default: state_nxt = S_IDLE;
                        endcase
                    end
                end
                S_WAIT: begin
                    cnt_nxt   = wait_delay ? cnt - 1'b1 : cnt;
                    state_nxt = !pndng[p] ? S_IDLE :
                                wait_delay ? ((cnt <= 2) ? S_ACK : S_WAIT) :
                                (!lfsr[p % 16] ? S_ACK : S_WAIT);
                end
                S_ACK:   state_nxt = S_GAP;
                default: state_nxt = S_IDLE;
            endcase
        end

        always_comb begin
            ack = state == S_ACK;
        end

`ifdef MESH_EDGE_CHECK_EN
        logic prev_pndng, prev_popin, err;
        logic [PCKG_SZ-1:0] prev_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                prev_pndng <= 1'b0;
                prev_popin <= 1'b0;
                prev_data  <= '0;
                err        <= 1'b0;
            end else begin
                prev_pndng <= pndng[p];
                prev_popin <= ack;
                prev_data  <= data_out[p*PCKG_SZ +: PCKG_SZ];
                err        <= err
                           || (pop[p] && !pndng_i_in[p])
                           || (prev_pndng && pndng[p] && !prev_popin
                               && (data_out[p*PCKG_SZ +: PCKG_SZ] != prev_data))
                           || (prev_popin && pndng[p]);
            end
        end

        assign err_sticky[p] = err;
`else
        assign err_sticky[p] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mesh_edge_ports.sv
// tb_mesh_edge_ports: randomized self-checking bench with a queue-based router and FIFO model
module tb_mesh_edge_ports;

    localparam int NP = 16;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] cfg_mode;
    logic [DW-1:0] cfg_delay;
    logic [NP-1:0] tx_valid, tx_ready, pndng_i_in, pop, pndng, popin, rx_valid, rx_ready, err_sticky;
    logic [NP*W-1:0] tx_data, data_out_i_in, data_out, rx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] rtr_mem [NP][256];
    logic [W-1:0] exp_mem [NP][256];
    int rtr_wr[NP], rtr_rd[NP], exp_wr[NP], exp_rd[NP], acks[NP], last_ack[NP];
    bit rtr_gap[NP];

    mesh_edge_ports #(.ROWS(4), .COLUMS(4), .PCKG_SZ(W), .FIFO_DEPTH(D), .DLY_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_mode      (cfg_mode),
        .cfg_delay     (cfg_delay),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .pop           (pop),
        .pndng         (pndng),
        .data_out      (data_out),
        .popin         (popin),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .err_sticky    (err_sticky)
    );

    always #5 clk = ~clk;

    // Router output: presents its queue head, drops pndng for one cycle after each consumption.
    task automatic router_drive();
        for (int p = 0; p < NP; p++) begin
            pndng[p] = !rtr_gap[p] && (rtr_rd[p] != rtr_wr[p]);
            data_out[p*W +: W] = (rtr_rd[p] != rtr_wr[p]) ? rtr_mem[p][rtr_rd[p]] : '0;
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            rtr_wr[p] = 0; rtr_rd[p] = 0; exp_wr[p] = 0; exp_rd[p] = 0;
            acks[p] = 0; last_ack[p] = -100; rtr_gap[p] = 0;
        end
        router_drive();
    endtask

    // One clock: router consumes on popin, RX pops are checked against the captured order.
    task automatic step();
        logic [NP-1:0] ack, rxp;
        ack = popin;
        rxp = rx_valid & rx_ready;
        for (int p = 0; p < NP; p++) begin
            if (ack[p]) begin
                checks++;
                if (pndng[p] !== 1'b1 || cyc - last_ack[p] < 2) begin
                    errors++;
                    $display("FAIL ack_proto port %0d cycle %0d: pndng=%b spacing=%0d, need pndng=1 spacing>=2",
                             p, cyc, pndng[p], cyc - last_ack[p]);
                end else begin
                    exp_mem[p][exp_wr[p]] = rtr_mem[p][rtr_rd[p]];
                    exp_wr[p]++;
                    rtr_rd[p]++;
                end
                last_ack[p] = cyc;
                acks[p]++;
            end
            rtr_gap[p] = ack[p] && pndng[p];
            if (rxp[p]) begin
                checks++;
                if (exp_rd[p] == exp_wr[p] || rx_data[p*W +: W] !== exp_mem[p][exp_rd[p]]) begin
                    errors++;
                    $display("FAIL rx_order port %0d: got %h want %h (pending %0d)", p, rx_data[p*W +: W],
                             exp_mem[p][exp_rd[p]], exp_wr[p] - exp_rd[p]);
                end
                exp_rd[p]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        router_drive();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks += 5;
        if (tx_ready !== '0) begin errors++; $display("FAIL reset_tx_ready got %h want 0", tx_ready); end
        if (pndng_i_in !== '0) begin errors++; $display("FAIL reset_pndng_i_in got %h want 0", pndng_i_in); end
        if (popin !== '0) begin errors++; $display("FAIL reset_popin got %h want 0", popin); end
        if (rx_valid !== '0) begin errors++; $display("FAIL reset_rx_valid got %h want 0", rx_valid); end
        if (err_sticky !== '0) begin errors++; $display("FAIL reset_err got %h want 0", err_sticky); end
        reset = 1'b0;
        step();
        checks++;
        if (tx_ready !== '1) begin errors++; $display("FAIL post_reset_tx_ready got %h want ffff", tx_ready); end
    endtask

    task automatic test_tx_order();
        for (int i = 0; i < 3; i++) begin
            tx_valid[3] = 1'b1;
            tx_data[3*W +: W] = W'(32'hA0 + i);
            step();
        end
        tx_valid = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pndng_i_in[3] !== 1'b1 || data_out_i_in[3*W +: W] !== 32'hA0) begin
                errors++;
                $display("FAIL tx_order_hold pndng=%b head=%h want 1/a0", pndng_i_in[3], data_out_i_in[3*W +: W]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            pop[3] = 1'b1;
            step();
            pop[3] = 1'b0;
            checks++;
            if (i < 2 && (pndng_i_in[3] !== 1'b1 || data_out_i_in[3*W +: W] !== W'(32'hA1 + i))) begin
                errors++;
                $display("FAIL tx_order_next pop %0d head=%h want %h", i, data_out_i_in[3*W +: W], 32'hA1 + i);
            end
            if (i == 2 && pndng_i_in[3] !== 1'b0) begin
                errors++;
                $display("FAIL tx_order_empty pndng=%b want 0", pndng_i_in[3]);
            end
        end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_ready[5] !== (i < 4)) begin
                errors++;
                $display("FAIL tx_full_ready after %0d pushes got %b want %b", i, tx_ready[5], i < 4);
            end
            tx_valid[5] = 1'b1;
            tx_data[5*W +: W] = W'(32'hB0 + i);
            step();
        end
        tx_valid = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out_i_in[5*W +: W] !== W'(32'hB0 + i) || pndng_i_in[5] !== 1'b1) begin
                errors++;
                $display("FAIL tx_full_head %0d got %h want %h", i, data_out_i_in[5*W +: W], 32'hB0 + i);
            end
            pop[5] = 1'b1;
            step();
            pop[5] = 1'b0;
            if (i == 0) begin
                checks++;
                if (tx_ready[5] !== 1'b1) begin errors++; $display("FAIL tx_full_reraise got %b want 1", tx_ready[5]); end
            end
        end
        checks++;
        if (pndng_i_in[5] !== 1'b0) begin errors++; $display("FAIL tx_full_fifth_word pndng=%b want 0", pndng_i_in[5]); end
    endtask

    task automatic test_tx_random();
        logic [W-1:0] m [NP][D];
        int cnt[NP], hd[NP];
        logic [NP-1:0] exp_ready, exp_pndng;
        for (int p = 0; p < NP; p++) begin cnt[p] = 0; hd[p] = 0; end
        for (int c = 0; c < 230; c++) begin
            for (int p = 0; p < NP; p++) begin
                tx_valid[p] = (c < 200) && ($urandom_range(0, 1) == 1);
                tx_data[p*W +: W] = $urandom;
                pop[p] = (cnt[p] > 0) && ($urandom_range(0, 2) == 0 || c >= 200);
                if (pop[p]) begin hd[p] = (hd[p] + 1) % D; cnt[p]--; end
                if (tx_valid[p] && cnt[p] + (pop[p] ? 1 : 0) < D) begin
                    m[p][(hd[p] + cnt[p]) % D] = tx_data[p*W +: W];
                    cnt[p]++;
                end
            end
            step();
            for (int p = 0; p < NP; p++) begin
                exp_ready[p] = cnt[p] < D;
                exp_pndng[p] = cnt[p] > 0;
            end
            checks++;
            if (tx_ready !== exp_ready || pndng_i_in !== exp_pndng) begin
                errors++;
                $display("FAIL tx_rand_flags cycle %0d ready=%h/%h pndng=%h/%h", c, tx_ready, exp_ready, pndng_i_in, exp_pndng);
            end
            for (int p = 0; p < NP; p++) begin
                if (cnt[p] > 0) begin
                    checks++;
                    if (data_out_i_in[p*W +: W] !== m[p][hd[p]]) begin
                        errors++;
                        $display("FAIL tx_rand_head port %0d got %h want %h", p, data_out_i_in[p*W +: W], m[p][hd[p]]);
                    end
                end
            end
        end
        tx_valid = '0;
        pop = '0;
    endtask

    task automatic test_delay();
        int dl[4] = '{3, 0, 5, 2};
        int lat;
        cfg_mode = 2'd1;
        rx_ready = '1;
        clear_model();
        for (int t = 0; t < 4; t++) begin
            cfg_delay = DW'(dl[t]);
            lat = (dl[t] == 0) ? 1 : (dl[t] < 2 ? 2 : dl[t]);
            rtr_mem[0][rtr_wr[0]] = $urandom;
            rtr_wr[0]++;
            router_drive();
            for (int k = 1; k <= lat; k++) begin
                step();
                checks++;
                if (popin[0] !== (k == lat)) begin
                    errors++;
                    $display("FAIL delay_popin delay %0d cycle +%0d got %b want %b", dl[t], k, popin[0], k == lat);
                end
            end
            step();
            checks++;
            if (rx_valid[0] !== 1'b1 || rx_data[W-1:0] !== rtr_mem[0][rtr_rd[0] - 1]) begin
                errors++;
                $display("FAIL delay_capture valid=%b data=%h want 1/%h", rx_valid[0], rx_data[W-1:0], rtr_mem[0][rtr_rd[0] - 1]);
            end
            repeat (3) step();
        end
    endtask

    task automatic test_lfsr();
        int i;
        bit done;
        cfg_mode = 2'd2;
        clear_model();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 100; k++) rtr_mem[p][k] = $urandom;
            rtr_wr[p] = 100;
        end
        router_drive();
        done = 1'b0;
        for (i = 0; i < 20000 && !done; i++) begin
            for (int p = 0; p < NP; p++) rx_ready[p] = ($urandom_range(0, 3) != 0);
            step();
            done = 1'b1;
            for (int p = 0; p < NP; p++) if (exp_rd[p] != 100) done = 1'b0;
        end
        rx_ready = '1;
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (acks[p] != 100 || exp_rd[p] != 100) begin
                errors++;
                $display("FAIL lfsr_count port %0d acks=%0d read=%0d want 100/100", p, acks[p], exp_rd[p]);
            end
        end
        checks++;
        if (err_sticky !== '0) begin errors++; $display("FAIL clean_traffic_err got %h want 0", err_sticky); end
    endtask

    task automatic test_backpressure();
        cfg_mode = 2'd0;
        rx_ready = '0;
        clear_model();
        for (int k = 0; k < 6; k++) rtr_mem[7][k] = $urandom;
        rtr_wr[7] = 6;
        router_drive();
        repeat (30) step();
        checks += 2;
        if (acks[7] != 4) begin errors++; $display("FAIL bp_acks got %0d want 4", acks[7]); end
        if (popin[7] !== 1'b0 || rx_valid[7] !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall popin=%b rx_valid=%b want 0/1", popin[7], rx_valid[7]);
        end
        rx_ready[7] = 1'b1;
        for (int i = 0; i < 100 && exp_rd[7] != 6; i++) step();
        checks++;
        if (acks[7] != 6 || exp_rd[7] != 6) begin
            errors++;
            $display("FAIL bp_resume acks=%0d read=%0d want 6/6", acks[7], exp_rd[7]);
        end
        rx_ready = '1;
    endtask

    task automatic test_reset_mid();
        int i;
        cfg_mode = 2'd0;
        rx_ready = '0;
        clear_model();
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 3; k++) rtr_mem[p][k] = $urandom;
            rtr_wr[p] = 3;
        end
        router_drive();
        for (i = 0; i < 50 && !(popin[0] === 1'b1 && acks[0] == 2); i++) begin
            tx_valid = (i < 2) ? '1 : '0;
            for (int p = 0; p < NP; p++) tx_data[p*W +: W] = $urandom;
            step();
        end
        tx_valid = '0;
        checks++;
        if (i == 50) begin errors++; $display("FAIL reset_mid_reach_ack timeout acks=%0d", acks[0]); end
        reset = 1'b1;
        step();
        checks += 4;
        if (tx_ready !== '0) begin errors++; $display("FAIL mid_reset_tx_ready got %h want 0", tx_ready); end
        if (pndng_i_in !== '0) begin errors++; $display("FAIL mid_reset_pndng got %h want 0", pndng_i_in); end
        if (popin !== '0) begin errors++; $display("FAIL mid_reset_popin got %h want 0", popin); end
        if (rx_valid !== '0) begin errors++; $display("FAIL mid_reset_rx_valid got %h want 0", rx_valid); end
        clear_model();
        reset = 1'b0;
        rx_ready = '1;
        repeat (10) step();
        checks++;
        if (rx_valid !== '0 || popin !== '0) begin
            errors++;
            $display("FAIL stale_after_reset rx_valid=%h popin=%h want 0/0", rx_valid, popin);
        end
`ifdef MESH_EDGE_CHECK_EN
        pop[2] = 1'b1;
        step();
        pop[2] = 1'b0;
        step();
        checks++;
        if (err_sticky[2] !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err_sticky[2]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (err_sticky !== '0) begin errors++; $display("FAIL err_clear got %h want 0", err_sticky); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        cfg_mode = 2'd0;
        cfg_delay = '0;
        tx_valid = '0;
        tx_data = '0;
        pop = '0;
        rx_ready = '1;
        clear_model();
        test_reset();
        test_tx_order();
        test_tx_full();
        test_tx_random();
        test_delay();
        test_lfsr();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
